// File: rtl/elevator_call_dispatcher.sv
// Elevator call dispatcher: latches call buttons, picks the next target floor by SCAN,
// then sequences the car through MOVE and a fixed door-open interval.
//
// state | meaning
// IDLE  | no car motion; dispatches as soon as any call is pending
// MOVE  | target driven on floor, waiting for cf to match (bounded by timeout)
// DOOR  | arrived, door held open for DOOR_CYCLES clocks
// FAULT | car failed to arrive in time; sticky until rst
module elevator_call_dispatcher #(
    parameter int NUM_FLOORS     = 4,
    parameter int FW             = 2,
    parameter int DOOR_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] btn,
    input  logic [FW-1:0]         cf,
    output logic [FW-1:0]         floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir,
    output logic                  busy,
    output logic                  arrived,
    output logic                  fault
);

    localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [DW-1:0] DOOR_LOAD = DW'(DOOR_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MOVE  = 2'd1,
        DOOR  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t                  state;
    logic [DW-1:0]           door;
    logic [TW-1:0]           tmo;
    logic [FW-1:0]           target;
    logic                    next_dir;
    logic                    here_hit;
    logic                    up_hit;
    logic                    dn_hit;
    logic [FW-1:0]           up_tgt;
    logic [FW-1:0]           dn_tgt;
    logic [NUM_FLOORS-1:0]   floor_oh;

    // SCAN target: current floor first, then nearest ahead in dir, then nearest behind.
    always_comb begin
        here_hit = 1'b0;
        up_hit   = 1'b0;
        dn_hit   = 1'b0;
        up_tgt   = '0;
        dn_tgt   = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (FW'(i) > cf)) begin
                up_hit = 1'b1;
                up_tgt = FW'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (FW'(i) < cf)) begin
                dn_hit = 1'b1;
                dn_tgt = FW'(i);
            end
            if (pending[i] && (FW'(i) == cf)) begin
                here_hit = 1'b1;
            end
        end
        if (here_hit) begin
            target = cf;
        end else if (dir) begin
            target = up_hit ? up_tgt : dn_tgt;
        end else begin
            target = dn_hit ? dn_tgt : up_tgt;
        end
        next_dir = here_hit ? dir : (target > cf);
    end

    always_comb begin
        floor_oh = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            floor_oh[i] = (FW'(i) == floor);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            floor   <= '0;
            pending <= '0;
            dir     <= 1'b1;
            busy    <= 1'b0;
            arrived <= 1'b0;
            fault   <= 1'b0;
            door    <= '0;
            tmo     <= '0;
        end else begin
            arrived <= 1'b0;
            pending <= pending | btn;
            case (state)
                IDLE: begin
                    if (|pending) begin
                        floor <= target;
                        dir   <= next_dir;
                        tmo   <= TMO_LOAD;
                        busy  <= 1'b1;
                        state <= MOVE;
                    end
                end
                MOVE: begin
                    if (cf == floor) begin
                        // Clear beats a same-cycle press of the arrival floor.
                        pending <= (pending | btn) & ~floor_oh;
                        arrived <= 1'b1;
                        door    <= DOOR_LOAD;
                        state   <= DOOR;
                    end else if (tmo == '0) begin
                        fault <= 1'b1;
                        state <= FAULT;
                    end else begin
                        tmo <= tmo - 1'b1;
                    end
                end
                DOOR: begin
                    if (door == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        door <= door - 1'b1;
                    end
                end
                FAULT: begin
                    fault <= 1'b1;
                end
            endcase
        end
    end

endmodule
